// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch/jump redirect controller: FSM state
// encoding and the performance counter width.
package branch_redirect_ctrl_pkg;

  localparam int CNT_W = 32;

  // RUN: normal issue; JWAIT: JALR held one cycle for its forwarded base;
  // SHADOW: cycle after an EX redirect, where ID holds a wrong-path instruction.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    JWAIT  = 2'd1,
    SHADOW = 2'd2
  } redir_state_e;

endpackage

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// Free-running event counter: increments by one on each enabled cycle and
// wraps naturally at 2^DATA_W.
module perf_counter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] count
);

  // Count enabled cycles; cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + DATA_W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect controller. Chooses the PC offset source (EX branch,
// ID JAL, ID JALR), raises pipeline flushes and stalls, and handles the JALR
// load-use hazard and the wrong-path shadow after an EX redirect. Only the
// FSM state and the two performance counters are registered.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        jal_ID,
  input  logic        jalr_ID,
  input  logic [4:0]  rs1_ID,
  input  logic        branch_EX,
  input  logic        taken_EX,
  input  logic [4:0]  rd_EX,
  input  logic        memread_EX,
  output logic        B_JUMP,
  output logic        jal,
  output logic        jalr,
  output logic        pc_redirect,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        stall_PC,
  output logic        stall_IF_ID,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
);

  redir_state_e state, state_nxt;

  logic ex_take;
  logic id_jal;
  logic id_jalr;
  logic hazard;
  logic sel_b;
  logic sel_jal;
  logic sel_jalr;
  logic stall;

  // An illegal JAL+JALR decode is treated as JAL, so JALR only counts alone.
  assign ex_take = branch_EX & taken_EX;
  assign id_jal  = jal_ID & id_valid;
  assign id_jalr = jalr_ID & ~jal_ID & id_valid;
  assign hazard  = id_jalr & memread_EX & (rd_EX == rs1_ID) & (rd_EX != 5'd0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and offset-select / stall decisions; EX redirect outranks
  // anything decoded in ID, and reset silences every control output.
  always_comb begin
    state_nxt = state;
    sel_b     = 1'b0;
    sel_jal   = 1'b0;
    sel_jalr  = 1'b0;
    stall     = 1'b0;
    if (rst) begin
      state_nxt = RUN;
    end else if (ex_take) begin
      sel_b     = 1'b1;
      state_nxt = SHADOW;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall     = 1'b1;
            state_nxt = JWAIT;
          end else if (id_jal) begin
            sel_jal = 1'b1;
          end else if (id_jalr) begin
            sel_jalr = 1'b1;
          end
        end
        JWAIT: begin
          // The load has left EX, so the base is now forwardable.
          state_nxt = RUN;
          if (id_jal) begin
            sel_jal = 1'b1;
          end else if (id_jalr) begin
            sel_jalr = 1'b1;
          end
        end
        SHADOW: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // Output mapping: a branch squashes both younger stages, an ID jump only
  // the fetched one; a stall holds PC/IF_ID and bubbles ID_EX.
  assign B_JUMP      = sel_b;
  assign jal         = sel_jal;
  assign jalr        = sel_jalr;
  assign pc_redirect = sel_b | sel_jal | sel_jalr;
  assign flush_IF_ID = sel_b | sel_jal | sel_jalr;
  assign flush_ID_EX = sel_b | stall;
  assign stall_PC    = stall;
  assign stall_IF_ID = stall;

  perf_counter #(
    .DATA_W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_redirect),
    .count (redirect_cnt)
  );

  perf_counter #(
    .DATA_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_PC),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl. Output bundle order:
// {B_JUMP, jal, jalr, pc_redirect, flush_IF_ID, flush_ID_EX, stall_PC, stall_IF_ID}
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, jal_ID, jalr_ID, branch_EX, taken_EX, memread_EX;
  logic [4:0]  rs1_ID, rd_EX;
  logic        B_JUMP, jal, jalr, pc_redirect, flush_IF_ID, flush_ID_EX;
  logic        stall_PC, stall_IF_ID;
  logic [31:0] redirect_cnt, stall_cnt;
  logic [7:0]  outs;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_redir = 32'd0;
  logic [31:0] exp_stall = 32'd0;

  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_BR    = 8'b1001_1100;
  localparam logic [7:0] O_JAL   = 8'b0101_1000;
  localparam logic [7:0] O_JALR  = 8'b0011_1000;
  localparam logic [7:0] O_STALL = 8'b0000_0111;

  assign outs = {B_JUMP, jal, jalr, pc_redirect, flush_IF_ID, flush_ID_EX, stall_PC, stall_IF_ID};

  branch_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .jal_ID       (jal_ID),
    .jalr_ID      (jalr_ID),
    .rs1_ID       (rs1_ID),
    .branch_EX    (branch_EX),
    .taken_EX     (taken_EX),
    .rd_EX        (rd_EX),
    .memread_EX   (memread_EX),
    .B_JUMP       (B_JUMP),
    .jal          (jal),
    .jalr         (jalr),
    .pc_redirect  (pc_redirect),
    .flush_IF_ID  (flush_IF_ID),
    .flush_ID_EX  (flush_ID_EX),
    .stall_PC     (stall_PC),
    .stall_IF_ID  (stall_IF_ID),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_valid = 1'b0; jal_ID = 1'b0; jalr_ID = 1'b0;
    branch_EX = 1'b0; taken_EX = 1'b0; memread_EX = 1'b0;
    rs1_ID = 5'd0; rd_EX = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_valid = 1'b1; jal_ID = 1'b1; jalr_ID = 1'b1;
    branch_EX = 1'b1; taken_EX = 1'b1; memread_EX = 1'b1;
    rs1_ID = 5'd5; rd_EX = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs, O_NONE); end
    n_cmp++;
    if (redirect_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_redir_cnt: got %h want 0", redirect_cnt); end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL reset_idle: got %b want %b", outs, O_NONE); end
  endtask

  // EX taken branch with a JAL in ID: branch wins, then SHADOW drops the JAL.
  task automatic test_ex_priority();
    @(negedge clk);
    branch_EX = 1'b1; taken_EX = 1'b1; jal_ID = 1'b1; id_valid = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_BR) begin n_bad++; $display("FAIL ex_over_jal: got %b want %b", outs, O_BR); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    branch_EX = 1'b0; taken_EX = 1'b0;
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL shadow_drops_jal: got %b want %b", outs, O_NONE); end
    n_cmp++;
    if (redirect_cnt !== exp_redir) begin n_bad++; $display("FAIL ex_redir_cnt: got %0d want %0d", redirect_cnt, exp_redir); end
    @(negedge clk); #1;
    n_cmp++;
    if (outs !== O_JAL) begin n_bad++; $display("FAIL jal_after_shadow: got %b want %b", outs, O_JAL); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (redirect_cnt !== exp_redir) begin n_bad++; $display("FAIL jal_redir_cnt: got %0d want %0d", redirect_cnt, exp_redir); end
  endtask

  // Back-to-back EX redirects: the second one still redirects while in SHADOW.
  task automatic test_back_to_back();
    @(negedge clk);
    branch_EX = 1'b1; taken_EX = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_BR) begin n_bad++; $display("FAIL b2b_first: got %b want %b", outs, O_BR); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    jalr_ID = 1'b1; id_valid = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_BR) begin n_bad++; $display("FAIL b2b_second: got %b want %b", outs, O_BR); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    branch_EX = 1'b0; taken_EX = 1'b0;
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL b2b_shadow: got %b want %b", outs, O_NONE); end
    @(negedge clk); #1;
    n_cmp++;
    if (outs !== O_JALR) begin n_bad++; $display("FAIL b2b_then_jalr: got %b want %b", outs, O_JALR); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (redirect_cnt !== exp_redir) begin n_bad++; $display("FAIL b2b_redir_cnt: got %0d want %0d", redirect_cnt, exp_redir); end
  endtask

  // lw x5 in EX, jalr x5 in ID: one bubble, then the JALR redirect.
  task automatic test_jalr_hazard();
    @(negedge clk);
    jalr_ID = 1'b1; id_valid = 1'b1; rs1_ID = 5'd5; memread_EX = 1'b1; rd_EX = 5'd5;
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin n_bad++; $display("FAIL hazard_stall: got %b want %b", outs, O_STALL); end
    exp_stall = exp_stall + 1;
    @(negedge clk);
    memread_EX = 1'b0; rd_EX = 5'd0;
    #1;
    n_cmp++;
    if (outs !== O_JALR) begin n_bad++; $display("FAIL hazard_jalr: got %b want %b", outs, O_JALR); end
    n_cmp++;
    if (stall_cnt !== exp_stall) begin n_bad++; $display("FAIL hazard_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL hazard_back_to_run: got %b want %b", outs, O_NONE); end
    n_cmp++;
    if (redirect_cnt !== exp_redir) begin n_bad++; $display("FAIL hazard_redir_cnt: got %0d want %0d", redirect_cnt, exp_redir); end
  endtask

  // No hazard when the load targets x0 or a different register; no jump without id_valid.
  task automatic test_jalr_no_hazard();
    @(negedge clk);
    jalr_ID = 1'b1; id_valid = 1'b1; rs1_ID = 5'd0; memread_EX = 1'b1; rd_EX = 5'd0;
    #1;
    n_cmp++;
    if (outs !== O_JALR) begin n_bad++; $display("FAIL rd0_jalr: got %b want %b", outs, O_JALR); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    rs1_ID = 5'd5; rd_EX = 5'd6;
    #1;
    n_cmp++;
    if (outs !== O_JALR) begin n_bad++; $display("FAIL rd_diff_jalr: got %b want %b", outs, O_JALR); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    jalr_ID = 1'b0; jal_ID = 1'b1; id_valid = 1'b0; memread_EX = 1'b0;
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL bubble_jal: got %b want %b", outs, O_NONE); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cnt !== exp_stall) begin n_bad++; $display("FAIL nohaz_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    n_cmp++;
    if (redirect_cnt !== exp_redir) begin n_bad++; $display("FAIL nohaz_redir_cnt: got %0d want %0d", redirect_cnt, exp_redir); end
  endtask

  // EX redirect arriving while the JALR waits: branch wins, JALR is wrong-path.
  task automatic test_jwait_ex_take();
    @(negedge clk);
    jalr_ID = 1'b1; id_valid = 1'b1; rs1_ID = 5'd7; memread_EX = 1'b1; rd_EX = 5'd7;
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin n_bad++; $display("FAIL jwait_enter: got %b want %b", outs, O_STALL); end
    exp_stall = exp_stall + 1;
    @(negedge clk);
    memread_EX = 1'b0; rd_EX = 5'd0; branch_EX = 1'b1; taken_EX = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_BR) begin n_bad++; $display("FAIL jwait_ex_wins: got %b want %b", outs, O_BR); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    branch_EX = 1'b0; taken_EX = 1'b0;
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL jwait_to_shadow: got %b want %b", outs, O_NONE); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (redirect_cnt !== exp_redir) begin n_bad++; $display("FAIL jwait_redir_cnt: got %0d want %0d", redirect_cnt, exp_redir); end
  endtask

  // Illegal decode with both jump flags resolves to JAL.
  task automatic test_both_jumps();
    @(negedge clk);
    jal_ID = 1'b1; jalr_ID = 1'b1; id_valid = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_JAL) begin n_bad++; $display("FAIL both_as_jal: got %b want %b", outs, O_JAL); end
    exp_redir = exp_redir + 1;
    @(negedge clk);
    clear_inputs();
  endtask

  // Reset asserted while in JWAIT: everything clears and the JALR is forgotten.
  task automatic test_reset_in_jwait();
    @(negedge clk);
    jalr_ID = 1'b1; id_valid = 1'b1; rs1_ID = 5'd5; memread_EX = 1'b1; rd_EX = 5'd5;
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin n_bad++; $display("FAIL rstj_stall: got %b want %b", outs, O_STALL); end
    @(negedge clk);
    memread_EX = 1'b0; rd_EX = 5'd0;
    rst = 1'b1;
    #1;
    exp_redir = 32'd0;
    exp_stall = 32'd0;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL rstj_outs: got %b want %b", outs, O_NONE); end
    n_cmp++;
    if (redirect_cnt !== 32'd0) begin n_bad++; $display("FAIL rstj_redir_cnt: got %0d want 0", redirect_cnt); end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rstj_stall_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL rstj_no_jalr: got %b want %b", outs, O_NONE); end
    @(negedge clk);
    jalr_ID = 1'b1; id_valid = 1'b1; rs1_ID = 5'd5; memread_EX = 1'b1; rd_EX = 5'd5;
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin n_bad++; $display("FAIL rstj_run_again: got %b want %b", outs, O_STALL); end
    exp_stall = exp_stall + 1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL rstj_no_select: got %b want %b", outs, O_NONE); end
    n_cmp++;
    if (stall_cnt !== exp_stall) begin n_bad++; $display("FAIL rstj_stall_cnt2: got %0d want %0d", stall_cnt, exp_stall); end
    n_cmp++;
    if (redirect_cnt !== exp_redir) begin n_bad++; $display("FAIL rstj_redir_cnt2: got %0d want %0d", redirect_cnt, exp_redir); end
  endtask

  // Redirect counter preloaded to all ones wraps to zero on one more redirect.
  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.u_redirect_cnt.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_redirect_cnt.count;
    #1;
    n_cmp++;
    if (redirect_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", redirect_cnt); end
    jal_ID = 1'b1; id_valid = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (redirect_cnt !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_zero: got %h want 00000000", redirect_cnt); end
    n_cmp++;
    if (stall_cnt !== exp_stall) begin n_bad++; $display("FAIL wrap_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  initial begin
    test_reset();
    test_ex_priority();
    test_back_to_back();
    test_jalr_hazard();
    test_jalr_no_hazard();
    test_jwait_ex_take();
    test_both_jumps();
    test_reset_in_jwait();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: id_valid  in  1  ID stage holds a real (non-bubble) instruction.
REQ-004 SHALL have port: jal_ID / jalr_ID  in  1 each  decoded JAL / JALR in ID.
REQ-005 SHALL have port: rs1_ID  in  5  JALR base register index.
REQ-006 SHALL have port: branch_EX  in  1  B-type instruction valid in EX.
REQ-007 SHALL have port: taken_EX  in  1  branch comparison result in EX.
REQ-008 SHALL have port: rd_EX  in  5, memread_EX  in  1  destination and load flag of EX instruction.
REQ-009 SHALL have port: B_JUMP / jal / jalr  out  1 each  one-hot-or-zero select to the offset mux.
REQ-010 SHALL have port: pc_redirect  out  1  PC takes PC-base + mux offset this cycle.
REQ-011 SHALL have port: flush_IF_ID / flush_ID_EX  out  1 each  clear the pipeline register at the next edge.
REQ-012 SHALL have port: stall_PC / stall_IF_ID  out  1 each  hold the register at the next edge.
REQ-013 SHALL have port: redirect_cnt / stall_cnt  out  32 each  performance counters.

Function
REQ-014 SHALL implement FSM states RUN, JWAIT (JALR base hazard), SHADOW (one cycle after an EX redirect).
REQ-015 SHALL drive all control outputs combinationally from inputs and state, registering only the state and counters.
REQ-016 SHALL define ex_take = branch_EX & taken_EX; when ex_take=1, it SHALL assert B_JUMP, pc_redirect, flush_IF_ID and flush_ID_EX, and set jal=jalr=0.
REQ-017 SHALL give EX redirect absolute priority over ID jumps; a jal_ID/jalr_ID present in the same cycle SHALL be ignored as wrong-path.
REQ-018 SHALL treat hazard = jalr_ID & id_valid & memread_EX & (rd_EX == rs1_ID) & (rd_EX != 0).
REQ-019 SHALL, in RUN with no ex_take and no hazard, assert jal (if jal_ID & id_valid) or jalr (if jalr_ID & id_valid), together with pc_redirect and flush_IF_ID, and SHALL NOT assert flush_ID_EX.
REQ-020 SHALL, in RUN with hazard and no ex_take, assert stall_PC, stall_IF_ID and flush_ID_EX (bubble insert), emit no select, and go to JWAIT.
REQ-021 SHALL, in JWAIT, perform the JALR redirect per REQ-019 (forwarded base now valid) and return to RUN; if ex_take occurs in JWAIT, REQ-016 SHALL win and the next state SHALL be SHADOW.
REQ-022 SHALL, on any ex_take, enter SHADOW; in SHADOW, it SHALL suppress ID-stage jumps regardless of id_valid and return to RUN after exactly one cycle (an ex_take in SHADOW SHALL still redirect and remain in SHADOW).
REQ-023 SHALL, if jal_ID and jalr_ID are both asserted (illegal decode), treat the instruction as jal.
REQ-024 SHALL never assert more than one of B_JUMP/jal/jalr; pc_redirect SHALL equal their OR.
REQ-025 SHALL increment redirect_cnt once per cycle with pc_redirect=1, and stall_cnt once per cycle with stall_PC=1; both SHALL wrap modulo 2^32.

Reset
REQ-026 SHALL, while rst=1, force state=RUN, counters=0, and all combinational outputs to 0 independent of inputs.
REQ-027 SHALL, if rst asserts mid-JWAIT or mid-SHADOW, abandon the pending action; the first post-reset cycle SHALL behave as RUN.

Structure
REQ-028 SHALL place the state encoding (2-bit, RUN=0, JWAIT=1, SHADOW=2) and the counter width constant in the shared CPU package.
REQ-029 SHALL instantiate one sub-module, perf_counter (32-bit, enable-increment, async reset), twice.

Verification
REQ-030 SHALL cover: EX taken branch while jal_ID=1 -> B_JUMP=1, jal=0, both flushes=1, next state SHADOW, redirect_cnt +1.
REQ-031 SHALL cover: lw x5 in EX (memread_EX=1, rd_EX=5), jalr in ID with rs1_ID=5 -> cycle 1: stall_PC=1, flush_ID_EX=1, no select; cycle 2: jalr=1, pc_redirect=1; stall_cnt=1.
REQ-032 SHALL cover: same as REQ-031 but rd_EX=0 -> immediate jalr redirect, no stall.
REQ-033 SHALL cover: SHADOW cycle with jal_ID=1 & id_valid=1 -> no redirect; following RUN cycle with jal_ID=1 -> jal=1.
REQ-034 SHALL cover: rst pulse during JWAIT -> all outputs 0 during reset, counters 0, no jalr redirect after release unless re-presented.
REQ-035 SHALL cover: redirect_cnt preloaded to 0xFFFFFFFF via forced redirects, one more redirect -> 0x00000000.
